// File: rtl/r_i_cpu_mc.sv
// Multi-cycle R/I-type MIPS-format core: FETCH -> DECODE -> EXEC -> WB, one instruction per 4+ cycles.
// Optional beq/bne support is compiled in when R_I_CPU_BRANCH_EN is defined.
module r_i_cpu_mc #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 6
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              hold,
  output logic              inst_req,
  output logic [PC_W-1:0]   inst_addr,
  input  logic [31:0]       inst_data,
  input  logic              inst_valid,
  output logic              ofa,
  output logic              zfa,
  output logic [DATA_W-1:0] douta,
  output logic              ill,
  output logic [1:0]        o_dbg_state
);
  // Handshake: the core holds inst_req high with a stable inst_addr while in FETCH
  // and not held; an instruction is taken only on a cycle where inst_valid & inst_req.
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_DECODE = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3} state_t;

  localparam int NREG = 2 ** REG_AW;
  localparam int MSB  = DATA_W - 1;

  state_t              r_state, w_next;
  logic [PC_W-1:0]     r_pc, w_pc_inc, w_pc_next;
  logic [31:0]         r_ir;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [DATA_W-1:0]   r_a, r_b, r_res;
  logic [4:0]          r_dst;
  logic                r_wr, r_ill;

  logic [5:0]          w_op, w_funct;
  logic [4:0]          w_rs, w_rt, w_rd, w_shamt;
  logic [15:0]         w_imm;
  logic [DATA_W-1:0]   w_imm_se, w_imm_ze, w_imm_hi, w_sum, w_diff, w_sumi;
  logic [DATA_W-1:0]   w_res;
  logic [4:0]          w_dst;
  logic                w_ovf, w_alu, w_br;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_shamt  = r_ir[10:6];
  assign w_funct  = r_ir[5:0];
  assign w_imm    = r_ir[15:0];
  assign w_imm_se = {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_imm_ze = {{(DATA_W-16){1'b0}}, w_imm};
  assign w_imm_hi = w_imm_ze << 16;
  assign w_sum    = r_a + r_b;
  assign w_diff   = r_a - r_b;
  assign w_sumi   = r_a + w_imm_se;

  assign inst_req    = rsta & ~hold & (r_state == S_FETCH);
  assign inst_addr   = r_pc;
  assign ill         = (r_state == S_WB) & r_ill;
  assign o_dbg_state = r_state;
  assign w_pc_inc    = r_pc + PC_W'(1);

  // r0 and addresses beyond the implemented file read as zero.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NREG) return '0;
    return r_regs[a[REG_AW-1:0]];
  endfunction

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (inst_valid && inst_req) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

`ifdef R_I_CPU_BRANCH_EN
  logic            r_taken, w_taken;
  logic [PC_W-1:0] w_off;
  assign w_off     = PC_W'($signed(w_imm));
  assign w_pc_next = r_taken ? (w_pc_inc + w_off) : w_pc_inc;
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta)                  r_taken <= 1'b0;
    else if (r_state == S_EXEC) r_taken <= w_taken;
  end
`else
  assign w_pc_next = w_pc_inc;
`endif

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_alu = 1'b1;
    w_br  = 1'b0;
    w_dst = w_rt;
`ifdef R_I_CPU_BRANCH_EN
    w_taken = 1'b0;
`endif
    case (w_op)
      6'h00: begin
        w_dst = w_rd;
        case (w_funct)
          6'h20: begin w_res = w_sum;  w_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]); end
          6'h22: begin w_res = w_diff; w_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]); end
          6'h24: w_res = r_a & r_b;
          6'h25: w_res = r_a | r_b;
          6'h26: w_res = r_a ^ r_b;
          6'h27: w_res = ~(r_a | r_b);
          6'h2A: w_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
          6'h00: w_res = r_b << w_shamt;
          6'h02: w_res = r_b >> w_shamt;
          default: w_alu = 1'b0;
        endcase
      end
      6'h08: begin w_res = w_sumi; w_ovf = (r_a[MSB] == w_imm_se[MSB]) && (w_sumi[MSB] != r_a[MSB]); end
      6'h0A: w_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_imm_se))};
      6'h0C: w_res = r_a & w_imm_ze;
      6'h0D: w_res = r_a | w_imm_ze;
      6'h0E: w_res = r_a ^ w_imm_ze;
      6'h0F: w_res = w_imm_hi;
`ifdef R_I_CPU_BRANCH_EN
      6'h04: begin w_alu = 1'b0; w_br = 1'b1; w_taken = (r_a == r_b); end
      6'h05: begin w_alu = 1'b0; w_br = 1'b1; w_taken = (r_a != r_b); end
`endif
      default: w_alu = 1'b0;
    endcase
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_dst <= '0;
      r_wr  <= 1'b0;
      r_ill <= 1'b0;
      ofa   <= 1'b0;
      zfa   <= 1'b0;
      douta <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (inst_valid && inst_req) r_ir <= inst_data;
        S_DECODE: begin
          r_a <= rd_reg(w_rs);
          r_b <= rd_reg(w_rt);
        end
        S_EXEC: begin
          r_res <= w_res;
          r_dst <= w_dst;
          r_wr  <= w_alu;
          r_ill <= ~(w_alu | w_br);
          if (w_alu) begin
            ofa <= w_ovf;
            zfa <= (w_res == '0);
          end
        end
        S_WB: begin
          if (r_wr) begin
            douta <= r_res;
            if (r_dst != 5'd0 && int'(r_dst) < NREG) r_regs[r_dst[REG_AW-1:0]] <= r_res;
          end
          r_pc <= w_pc_next;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_r_i_cpu_mc.sv
// Directed-program bench for r_i_cpu_mc: driver feeds instructions, monitor checks each retired result.
module tb_r_i_cpu_mc;
  localparam int EW = 41;  // {douta[31:0], ofa, zfa, ill, next_pc[5:0]}

  logic        clka = 1'b0;
  logic        rsta, hold, inst_valid;
  logic [31:0] inst_data;
  logic        inst_req, ofa, zfa, ill;
  logic [5:0]  inst_addr;
  logic [31:0] douta;
  logic [1:0]  o_dbg_state;

  int checks = 0, failures = 0;
  int cyc = 0, exp_pc = 0, last_acc = 0, prev_acc = 0;
  logic [EW-1:0] exp_q[$];
  logic wb_seen = 1'b0, ill_wb = 1'b0;

  r_i_cpu_mc #(.DATA_W(32), .REG_AW(5), .PC_W(6)) dut (
    .clka(clka), .rsta(rsta), .hold(hold), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_data(inst_data), .inst_valid(inst_valid), .ofa(ofa), .zfa(zfa), .douta(douta),
    .ill(ill), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // ---------------- driver ----------------
  task automatic fetch(input logic [31:0] ins, input int dly);
    int n = 0;
    while (!inst_req && n < 100) begin @(negedge clka); n++; end
    chk("req_timeout", 64'(n >= 100), 64'(0));
    chk("fetch_addr", 64'(inst_addr), 64'(exp_pc));
    inst_data = ins;
    for (int d = 0; d < dly; d++) begin
      @(negedge clka);
      chk("wait_state", 64'(o_dbg_state), 64'(0));
    end
    inst_valid = 1'b1;
    prev_acc = last_acc;
    last_acc = cyc;
    @(negedge clka);
    inst_valid = 1'b0;
    chk("decode_state", 64'(o_dbg_state), 64'(1));
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] d, input logic o, input logic z,
                       input logic il, input int dly = 0, input int nxt = -1);
    int np;
    np = (nxt < 0) ? ((exp_pc + 1) & 63) : nxt;
    exp_q.push_back({d, o, z, il, 6'(np)});
    fetch(ins, dly);
    exp_pc = np;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clka) begin
    logic [EW-1:0] e;
    if (!rsta) wb_seen = 1'b0;
    else begin
      if (wb_seen) begin
        wb_seen = 1'b0;
        if (exp_q.size() == 0) chk("queue_empty", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("mon_douta", 64'(douta), 64'(e[40:9]));
          chk("mon_ofa", 64'(ofa), 64'(e[8]));
          chk("mon_zfa", 64'(zfa), 64'(e[7]));
          chk("mon_ill_wb", 64'(ill_wb), 64'(e[6]));
          chk("mon_ill_after", 64'(ill), 64'(0));
          chk("mon_pc", 64'(inst_addr), 64'(e[5:0]));
        end
      end
      if (o_dbg_state == 2'd3) begin
        wb_seen = 1'b1;
        ill_wb  = ill;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rsta = 1'b0; hold = 1'b0; inst_valid = 1'b0; inst_data = '0;
    repeat (3) @(negedge clka);
    chk("rst_douta", 64'(douta), 64'(0));
    chk("rst_flags", 64'({ofa, zfa, ill}), 64'(0));
    chk("rst_req", 64'(inst_req), 64'(0));
    chk("rst_addr", 64'(inst_addr), 64'(0));
    chk("rst_state", 64'(o_dbg_state), 64'(0));
    rsta = 1'b1;
    #1;

    // basic program, 4 cycles per instruction
    issue(i_ins(8, 0, 1, 5), 32'd5, 0, 0, 0);
    issue(i_ins(8, 0, 2, 7), 32'd7, 0, 0, 0);
    chk("cycles_per_inst", 64'(last_acc - prev_acc), 64'(4));
    issue(r_ins(1, 2, 3, 0, 'h20), 32'd12, 0, 0, 0);
    chk("cycles_per_inst2", 64'(last_acc - prev_acc), 64'(4));

    // overflow and zero flag
    issue(i_ins('h0F, 0, 1, 'h7FFF), 32'h7FFF0000, 0, 0, 0);
    issue(i_ins('h0D, 1, 1, 'hFFFF), 32'h7FFFFFFF, 0, 0, 0);
    issue(i_ins(8, 1, 2, 1), 32'h80000000, 1, 0, 0);
    issue(r_ins(2, 2, 3, 0, 'h22), 32'h0, 0, 1, 0);

    // remaining ALU ops with r1=7FFFFFFF, r2=80000000, r3=0
    issue(r_ins(2, 1, 4, 0, 'h2A), 32'h1, 0, 0, 0);
    issue(i_ins('h0A, 1, 4, -1), 32'h0, 0, 1, 0);
    issue(r_ins(0, 1, 4, 4, 'h00), 32'hFFFFFFF0, 0, 0, 0);
    issue(r_ins(0, 2, 4, 31, 'h02), 32'h1, 0, 0, 0);
    issue(r_ins(1, 3, 4, 0, 'h27), 32'h80000000, 0, 0, 0);
    issue(i_ins('h0E, 1, 4, 'hFFFF), 32'h7FFF0000, 0, 0, 0);
    issue(i_ins('h0C, 2, 4, 'hFFFF), 32'h0, 0, 1, 0);
    issue(r_ins(1, 2, 4, 0, 'h26), 32'hFFFFFFFF, 0, 0, 0);
    issue(r_ins(2, 1, 4, 0, 'h22), 32'h1, 1, 0, 0);
    issue(r_ins(1, 1, 4, 0, 'h20), 32'hFFFFFFFE, 1, 0, 0);
    issue(i_ins('h3F, 1, 4, 0), 32'hFFFFFFFE, 1, 0, 1);
    issue(r_ins(1, 2, 4, 0, 'h24), 32'h0, 0, 1, 0);
    issue(r_ins(1, 2, 4, 0, 'h25), 32'hFFFFFFFF, 0, 0, 0);

    // r0 writes dropped, illegal funct
    issue(i_ins(8, 0, 0, 9), 32'd9, 0, 0, 0);
    issue(r_ins(1, 2, 5, 0, 'h3F), 32'd9, 0, 0, 1);
    issue(r_ins(0, 0, 5, 0, 'h25), 32'd0, 0, 1, 0);

    // hold in FETCH ignores inst_valid; late inst_valid
    n = 0;
    while (o_dbg_state != 2'd0 && n < 20) begin @(negedge clka); n++; end
    hold = 1'b1; inst_valid = 1'b1; inst_data = i_ins(8, 0, 6, 77);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_req", 64'(inst_req), 64'(0));
      chk("hold_addr", 64'(inst_addr), 64'(exp_pc));
      chk("hold_state", 64'(o_dbg_state), 64'(0));
      @(negedge clka);
    end
    inst_valid = 1'b0; hold = 1'b0;
    #1;
    issue(i_ins(8, 0, 7, -1), 32'hFFFFFFFF, 0, 0, 0, 3);

    // run up to PC=63 and wrap
    while (exp_pc != 63) issue(i_ins('h0D, 0, 6, exp_pc), 32'(exp_pc), 0, (exp_pc == 0), 0);
    issue(i_ins('h0D, 0, 6, 63), 32'd63, 0, 0, 0);

    // reset during EXEC aborts the add
    fetch(r_ins(1, 2, 3, 0, 'h20), 0);
    @(negedge clka);
    chk("abort_in_exec", 64'(o_dbg_state), 64'(2));
    rsta = 1'b0;
    #1;
    chk("abort_douta", 64'(douta), 64'(0));
    chk("abort_flags", 64'({ofa, zfa, ill, inst_req}), 64'(0));
    chk("abort_addr", 64'(inst_addr), 64'(0));
    @(negedge clka);
    rsta = 1'b1;
    exp_pc = 0;
    #1;

    // branches
    issue(i_ins(8, 0, 1, 3), 32'd3, 0, 0, 0);
    issue(i_ins(8, 0, 2, 3), 32'd3, 0, 0, 0);
    issue(r_ins(3, 0, 8, 0, 'h20), 32'd0, 0, 1, 0);
    issue(i_ins('h0D, 0, 9, 1), 32'd1, 0, 0, 0);
`ifdef R_I_CPU_BRANCH_EN
    issue(i_ins(4, 1, 2, -1), 32'd1, 0, 0, 0, 0, 4);
    issue(i_ins(5, 1, 2, 5), 32'd1, 0, 0, 0);
`else
    issue(i_ins(4, 1, 2, -1), 32'd1, 0, 0, 1);
    issue(i_ins(5, 1, 2, 5), 32'd1, 0, 0, 1);
`endif
    issue(i_ins('h0D, 0, 9, 2), 32'd2, 0, 0, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clka); n++; end
    chk("drain", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
